// File: rtl/seq_stim_pkg.sv
// Shared types and default widths for the sequenced stimulus generator.
package seq_stim_pkg;

  localparam int unsigned DefGapW = 4;
  localparam int unsigned DefCntW = 8;

  // Stimulus flavour selected per burst.
  typedef enum logic [1:0] {
    ModeOk  = 2'd0,
    ModeClk = 2'd1,
    ModeNoB = 2'd2,
    ModeNoD = 2'd3
  } mode_e;

  // One iteration is A, optional GAP run, B, D; a burst ends with a single DONE cycle.
  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StA    = 3'd1,
    StGap  = 3'd2,
    StB    = 3'd3,
    StD    = 3'd4,
    StDone = 3'd5
  } state_e;

endpackage

// File: rtl/seq_stim_gen_if.sv
// Request and strobe bundle between a burst requester (master) and the generator (slave).
interface seq_stim_gen_if
  import seq_stim_pkg::*;
#(
  parameter int unsigned GAP_W = DefGapW,
  parameter int unsigned CNT_W = DefCntW
);

  logic             start;
  mode_e            mode;
  logic [GAP_W-1:0] gap;
  logic [CNT_W-1:0] count;
  logic             abort;

  logic             a_sysclk;
  logic             a_clk;
  logic             b_sysclk;
  logic             d_clk;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;

  modport master (
    output start, mode, gap, count, abort,
    input  a_sysclk, a_clk, b_sysclk, d_clk, busy, done, remaining
  );

  modport slave (
    input  start, mode, gap, count, abort,
    output a_sysclk, a_clk, b_sysclk, d_clk, busy, done, remaining
  );

endinterface

// File: rtl/seq_stim_gen.sv
// Sequenced a/b/d strobe generator: repeats A, GAP x gap, B, D for count iterations,
// then pulses done. Every output is a flop so nothing leaks combinationally from inputs.
module seq_stim_gen
  import seq_stim_pkg::*;
#(
  parameter int unsigned GAP_W = DefGapW,
  parameter int unsigned CNT_W = DefCntW
) (
  input logic           clk,
  input logic           rst,
  seq_stim_gen_if.slave bus
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;

  logic a_sysclk_q, a_sysclk_d;
  logic a_clk_q, a_clk_d;
  logic b_sysclk_q, b_sysclk_d;
  logic d_clk_q, d_clk_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Next state, counters, and strobes decoded from the state being entered
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    rem_d     = rem_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d = bus.mode;
          gap_d  = bus.gap;
          if (bus.count != '0) begin
            // Capture and first entry to A coincide, so load count already decremented.
            state_d = StA;
            rem_d   = bus.count - 1'b1;
          end else begin
            state_d = StDone;
            rem_d   = '0;
          end
        end
      end
      StA: begin
        if (gap_q != '0) begin
          state_d   = StGap;
          gap_cnt_d = gap_q - 1'b1;
        end else begin
          state_d = StB;
        end
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d = StB;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      StB: begin
        state_d = StD;
      end
      StD: begin
        if (rem_q != '0) begin
          state_d = StA;
          rem_d   = rem_q - 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort only matters once a burst is running; in IDLE a coincident start wins.
    if (bus.abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      rem_d     = '0;
      gap_cnt_d = '0;
    end

    a_sysclk_d = (state_d == StA) && (mode_d != ModeClk);
    a_clk_d    = (state_d == StA) && (mode_d == ModeClk);
    b_sysclk_d = (state_d == StB) && (mode_d != ModeNoB);
    d_clk_d    = (state_d == StD) && (mode_d != ModeNoD);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
  end

  // State, captured configuration, counters and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      mode_q     <= ModeOk;
      gap_q      <= '0;
      gap_cnt_q  <= '0;
      rem_q      <= '0;
      a_sysclk_q <= 1'b0;
      a_clk_q    <= 1'b0;
      b_sysclk_q <= 1'b0;
      d_clk_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      gap_q      <= gap_d;
      gap_cnt_q  <= gap_cnt_d;
      rem_q      <= rem_d;
      a_sysclk_q <= a_sysclk_d;
      a_clk_q    <= a_clk_d;
      b_sysclk_q <= b_sysclk_d;
      d_clk_q    <= d_clk_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.a_sysclk  = a_sysclk_q;
  assign bus.a_clk     = a_clk_q;
  assign bus.b_sysclk  = b_sysclk_q;
  assign bus.d_clk     = d_clk_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.remaining = rem_q;

endmodule

// File: doc/seq_stim_gen.md
SEQ_STIM_GEN -- requirements
Module: seq_stim_gen

Interface
REQ-001 Parameter GAP_W, default 4, width of the programmable a-to-b gap.
REQ-002 Parameter CNT_W, default 8, width of the iteration count.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request; sampled only in IDLE.
REQ-006 mode  input  2  stimulus mode (mode_e), captured with start.
REQ-007 gap  input  GAP_W  idle cycles between a-phase and b-phase, captured with start.
REQ-008 count  input  CNT_W  number of iterations, captured with start.
REQ-009 abort  input  1  synchronous abort of a running burst.
REQ-010 a_sysclk  output  1  a-strobe, sysclk-flavour stimulus.
REQ-011 a_clk  output  1  a-strobe, clk-flavour stimulus.
REQ-012 b_sysclk  output  1  b-strobe.
REQ-013 d_clk  output  1  d-strobe (sequence terminator).
REQ-014 busy  output  1  burst in progress.
REQ-015 done  output  1  one-cycle pulse on normal burst completion.
REQ-016 remaining  output  CNT_W  iterations not yet started.

Function
REQ-017 FSM states SHALL be IDLE, A, GAP, B, D, DONE.
REQ-018 All outputs SHALL be registered (direct decode of registered state/counters, no input-to-output path).
REQ-019 IDLE + start=1 at edge T SHALL capture mode/gap/count; count!=0 -> state A at T+1; count==0 -> DONE at T+1 (no strobes).
REQ-020 A SHALL last 1 cycle: a_sysclk=1 for modes OK/NO_B/NO_D, a_clk=1 for mode CLK; exactly one a-strobe high.
REQ-021 A -> GAP if captured gap!=0, else A -> B; GAP SHALL last exactly gap cycles, all strobes low.
REQ-022 B SHALL last 1 cycle with b_sysclk=1, except mode NO_B (b_sysclk held 0, cycle still consumed).
REQ-023 D SHALL last 1 cycle with d_clk=1, except mode NO_D (d_clk held 0, cycle still consumed).
REQ-024 remaining SHALL load count on capture and decrement by 1 on each entry to A; D -> A if remaining!=0, else D -> DONE.
REQ-025 DONE SHALL last 1 cycle with done=1, then -> IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE (includes DONE cycle).
REQ-027 Iteration length SHALL be 3+gap cycles; gap=0,count=1: a@T+1, b@T+2, d@T+3, done@T+4, busy T+1..T+4.
REQ-028 start while busy SHALL be ignored (no re-capture, no effect on counters).
REQ-029 abort=1 in any non-IDLE state SHALL force IDLE next edge, all strobes 0, done NOT pulsed, remaining cleared to 0.
REQ-030 abort and start simultaneous in IDLE: start SHALL win (abort ignored in IDLE).
REQ-031 abort in DONE SHALL suppress nothing further; done already asserted that cycle stands, state -> IDLE.
REQ-032 Counter widths SHALL not wrap: remaining never decremented below 0; count max (2^CNT_W-1) fully supported.

Reset
REQ-033 rst=1 SHALL asynchronously force IDLE, all strobes 0, busy=0, done=0, remaining=0, captured mode/gap cleared.
REQ-034 Reset deassertion mid-clock SHALL produce no strobe before the first start after reset.
REQ-035 Reset asserted mid-burst SHALL terminate it identically to REQ-033, no done pulse.

Structure
REQ-036 Package seq_stim_pkg SHALL hold mode_e (OK=0, CLK=1, NO_B=2, NO_D=3), state_e, and default GAP_W/CNT_W constants.
REQ-037 Single module, no sub-modules; gap counter and iteration counter inline.

Verification
REQ-038 mode=OK, gap=0, count=1, start@T -> a_sysclk@T+1, b_sysclk@T+2, d_clk@T+3, done@T+4, busy low @T+5.
REQ-039 mode=CLK, gap=3, count=2 -> a_clk@T+1,T+7; b_sysclk@T+5,T+11; d_clk@T+6,T+12; done@T+13; a_sysclk never 1.
REQ-040 mode=NO_B, gap=0, count=3 -> b_sysclk never 1, d_clk@T+3,T+6,T+9, done@T+10; mode=NO_D analogous, d_clk never 1.
REQ-041 count=0 -> no strobes, done@T+1, busy only @T+1; start pulsed again @T+3 while idle -> accepted.
REQ-042 mode=OK, gap=2, count=5, abort@first GAP cycle of iteration 2 -> idle next edge, remaining=0, no done, start during burst ignored.
REQ-043 rst asserted between clock edges during B -> b_sysclk, busy drop immediately (before next edge), no done after release.
